// File: rtl/pattern_sequencer_if.sv
// Control bundle between the VGA test pattern front end and the pattern sequencer.
interface pattern_sequencer_if;
    logic       i_frame_strobe;
    logic       i_next;
    logic       i_prev;
    logic       i_enable;
    logic       i_auto;
    logic [3:0] o_pattern;
    logic       o_busy;

    modport master (
        output i_frame_strobe, i_next, i_prev, i_enable, i_auto,
        input  o_pattern, o_busy
    );

    modport slave (
        input  i_frame_strobe, i_next, i_prev, i_enable, i_auto,
        output o_pattern, o_busy
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Frame-aligned pattern select for the VGA test pattern generator, with blank frames between changes.
// Auto-advance dwell timer is built only when PATTERN_SEQ_AUTO_EN is defined.
module pattern_sequencer #(
    parameter int MIN_PATTERN  = 1,
    parameter int MAX_PATTERN  = 8,
    parameter int INIT_PATTERN = 1,
    parameter int BLANK_FRAMES = 2,
    parameter int DWELL_FRAMES = 120
) (
    input  logic                i_clk,
    input  logic                i_rst,
    pattern_sequencer_if.slave  bus
);
    // state | meaning
    // SHOW  | current pattern on screen; a pending change starts at the next strobe
    // BLANK | pattern 0 on screen for BLANK_FRAMES frames before the target appears
    typedef enum logic {SHOW, BLANK} state_t;

    localparam logic [3:0] MIN_P      = 4'(MIN_PATTERN);
    localparam logic [3:0] MAX_P      = 4'(MAX_PATTERN);
    localparam logic [3:0] INIT_P     = 4'(INIT_PATTERN);
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES - 1);

    state_t     state;
    logic [3:0] target;
    logic [3:0] target_n;
    logic [3:0] blank_cnt;
    logic [3:0] pattern_q;
    logic       pending;
    logic       pending_n;
    logic       off;
    logic       busy_q;
    logic       man_next;
    logic       man_prev;
    logic       auto_req;
    logic       fwd;

    function automatic logic [3:0] step_up(input logic [3:0] p);
        return (p >= MAX_P) ? MIN_P : p + 4'd1;
    endfunction

    function automatic logic [3:0] step_dn(input logic [3:0] p);
        return (p <= MIN_P) ? MAX_P : p - 4'd1;
    endfunction

    // Simultaneous next and prev cancel each other rather than picking a winner.
    always_comb begin
        man_next  = bus.i_next & ~bus.i_prev;
        man_prev  = bus.i_prev & ~bus.i_next;
        fwd       = man_next | auto_req;
        target_n  = fwd ? step_up(target) : (man_prev ? step_dn(target) : target);
        pending_n = pending | fwd | man_prev;
    end

`ifdef PATTERN_SEQ_AUTO_EN
    localparam logic [11:0] DWELL_LAST = 12'(DWELL_FRAMES - 1);

    logic [11:0] dwell;
    logic        dwell_run;
    logic        enter_show;

    assign dwell_run  = bus.i_auto & bus.i_enable & ~off & (state == SHOW) & bus.i_frame_strobe;
    assign auto_req   = dwell_run & ~man_next & ~man_prev & (dwell == DWELL_LAST);
    assign enter_show = bus.i_frame_strobe & bus.i_enable &
                        (((state == BLANK) & ~off & (blank_cnt == 4'd0)) |
                         ((off | pending_n) & (BLANK_FRAMES == 0)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dwell <= '0;
        end else if (man_next | man_prev | enter_show) begin
            dwell <= '0;
        end else if (dwell_run) begin
            dwell <= auto_req ? 12'd0 : dwell + 12'd1;
        end
    end
`else
    logic unused_auto;

    assign auto_req    = 1'b0;
    assign unused_auto = bus.i_auto;
`endif

    // A disable holds the FSM where it is; re-enabling restarts the blanking sequence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= SHOW;
            target    <= INIT_P;
            pending   <= 1'b0;
            off       <= 1'b0;
            blank_cnt <= 4'd0;
            pattern_q <= INIT_P;
            busy_q    <= 1'b0;
        end else begin
            target  <= target_n;
            pending <= pending_n;
            busy_q  <= pending_n | (state == BLANK);
            if (bus.i_frame_strobe) begin
                if (!bus.i_enable) begin
                    pattern_q <= 4'd0;
                    off       <= 1'b1;
                end else if ((state == BLANK) && !off) begin
                    if (blank_cnt == 4'd0) begin
                        pattern_q <= target_n;
                        pending   <= 1'b0;
                        state     <= SHOW;
                        busy_q    <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt - 4'd1;
                    end
                end else if (off || pending_n) begin
                    off     <= 1'b0;
                    pending <= 1'b0;
                    if (BLANK_FRAMES > 0) begin
                        pattern_q <= 4'd0;
                        blank_cnt <= BLANK_LAST;
                        state     <= BLANK;
                        busy_q    <= 1'b1;
                    end else begin
                        pattern_q <= target_n;
                        state     <= SHOW;
                        busy_q    <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.o_pattern = pattern_q;
    assign bus.o_busy    = busy_q;
endmodule
